// File: rtl/audio_arb_pkg.sv
// audio_arb_pkg: shared types and constants for the audio source arbiter.
//   arb_state_e - arbiter state, also the encoding seen on active_source
//   Src*        - source codes used to tag an open sample window
//   SampleWidth - codec sample width; sample_t / ZeroSample derive from it
package audio_arb_pkg;

  localparam int unsigned SampleWidth = 16;

  typedef logic [SampleWidth-1:0] sample_t;

  localparam sample_t ZeroSample = '0;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSong  = 2'd1,
    StKey   = 2'd2,
    StDrain = 2'd3
  } arb_state_e;

  localparam logic [1:0] SrcNone = 2'd0;
  localparam logic [1:0] SrcSong = 2'd1;
  localparam logic [1:0] SrcKey  = 2'd2;

  // Which source, if any, feeds the codec in a given state.
  function automatic logic [1:0] source_of(arb_state_e st);
    logic [1:0] src;
    src = SrcNone;
    if (st == StSong) src = SrcSong;
    if (st == StKey)  src = SrcKey;
    return src;
  endfunction

endpackage

// File: rtl/audio_source_arbiter_if.sv
// audio_source_arbiter_if: signal bundle between the arbiter and its surroundings.
//   master - environment side (controls, source samples in; enables, codec sample out)
//   slave  - arbiter side
//   play, key_val, beat        : mode controls
//   generate_next_sample       : codec sample request (level, edge-detected inside)
//   song_sample(_ready)        : song player output
//   key_note_sample(_ready)    : keyboard voice output
//   song_enable, key_enable    : source enables
//   key_code                   : beat-quantised key code
//   sample_out(_ready)         : forwarded sample and one-cycle valid
//   active_source, sample_miss : state encoding and sticky miss flag
interface audio_source_arbiter_if;
  import audio_arb_pkg::*;

  logic       play;
  logic [3:0] key_val;
  logic       beat;
  logic       generate_next_sample;
  sample_t    song_sample;
  logic       song_sample_ready;
  sample_t    key_note_sample;
  logic       key_note_sample_ready;
  logic       song_enable;
  logic       key_enable;
  logic [3:0] key_code;
  sample_t    sample_out;
  logic       sample_out_ready;
  logic [1:0] active_source;
  logic       sample_miss;

  modport master (
    output play, key_val, beat, generate_next_sample,
    output song_sample, song_sample_ready, key_note_sample, key_note_sample_ready,
    input  song_enable, key_enable, key_code, sample_out, sample_out_ready,
    input  active_source, sample_miss
  );

  modport slave (
    input  play, key_val, beat, generate_next_sample,
    input  song_sample, song_sample_ready, key_note_sample, key_note_sample_ready,
    output song_enable, key_enable, key_code, sample_out, sample_out_ready,
    output active_source, sample_miss
  );

endinterface

// File: rtl/sample_handoff.sv
// sample_handoff: turns codec request edges into exactly one forwarded sample each.
//   clk_i, rst_ni           : clock, synchronous active-low reset
//   generate_next_sample_i  : request level; one event per 0->1 transition
//   active_source_i         : current arbiter state, selects the live source
//   song_*_i, key_*_i       : source samples and ready pulses
//   sample_o, sample_valid_o: registered sample and one-cycle valid
//   sample_miss_o           : sticky, set on timeout or overrun substitution
//   drain_ack_o             : a request was answered while draining (combinational)
module sample_handoff
  import audio_arb_pkg::*;
#(
  parameter int unsigned SAMPLE_TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       generate_next_sample_i,
  input  arb_state_e active_source_i,
  input  sample_t    song_sample_i,
  input  logic       song_ready_i,
  input  sample_t    key_sample_i,
  input  logic       key_ready_i,
  output sample_t    sample_o,
  output logic       sample_valid_o,
  output logic       sample_miss_o,
  output logic       drain_ack_o
);

  // Timer counts cycles since the request event; the event cycle itself is 1.
  localparam logic [7:0] TimeoutLast = 8'(SAMPLE_TIMEOUT - 1);

  logic       gen_prev_q;
  logic       req_q;
  logic       pending_q, pending_d;
  logic [7:0] timer_q, timer_d;
  logic [1:0] win_src_q, win_src_d;
  sample_t    sample_q, sample_d;
  logic       valid_q, valid_d;
  logic       miss_q, miss_d;

  logic [1:0] cur_src;
  logic       streaming;
  logic       sel_ready;
  sample_t    sel_sample;

  assign cur_src   = source_of(active_source_i);
  assign streaming = (cur_src != SrcNone);

  always_comb begin
    sel_ready  = 1'b0;
    sel_sample = ZeroSample;
    unique case (cur_src)
      SrcSong: begin
        sel_ready  = song_ready_i;
        sel_sample = song_sample_i;
      end
      SrcKey: begin
        sel_ready  = key_ready_i;
        sel_sample = key_sample_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    pending_d   = pending_q;
    timer_d     = timer_q;
    win_src_d   = win_src_q;
    sample_d    = sample_q;
    valid_d     = 1'b0;
    miss_d      = miss_q;
    drain_ack_o = 1'b0;

    if (pending_q && (cur_src != win_src_q)) begin
      // Source switched under an open window: close it quietly with silence.
      valid_d   = 1'b1;
      sample_d  = ZeroSample;
      pending_d = 1'b0;
      if (req_q) begin
        if (streaming) begin
          pending_d = 1'b1;
          timer_d   = 8'd1;
          win_src_d = cur_src;
        end else begin
          drain_ack_o = (active_source_i == StDrain);
        end
      end
    end else if (req_q) begin
      if (!streaming) begin
        valid_d     = 1'b1;
        sample_d    = ZeroSample;
        drain_ack_o = (active_source_i == StDrain);
      end else if (pending_q) begin
        // Overrun: the old window is answered with silence, the new one opens now.
        valid_d   = 1'b1;
        sample_d  = ZeroSample;
        miss_d    = 1'b1;
        pending_d = 1'b1;
        timer_d   = 8'd1;
        win_src_d = cur_src;
      end else if (sel_ready) begin
        valid_d  = 1'b1;
        sample_d = sel_sample;
      end else begin
        pending_d = 1'b1;
        timer_d   = 8'd1;
        win_src_d = cur_src;
      end
    end else if (pending_q) begin
      if (sel_ready) begin
        valid_d   = 1'b1;
        sample_d  = sel_sample;
        pending_d = 1'b0;
      end else if (timer_q >= TimeoutLast) begin
        valid_d   = 1'b1;
        sample_d  = ZeroSample;
        miss_d    = 1'b1;
        pending_d = 1'b0;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      gen_prev_q <= 1'b0;
      req_q      <= 1'b0;
      pending_q  <= 1'b0;
      timer_q    <= '0;
      win_src_q  <= SrcNone;
      sample_q   <= ZeroSample;
      valid_q    <= 1'b0;
      miss_q     <= 1'b0;
    end else begin
      gen_prev_q <= generate_next_sample_i;
      req_q      <= generate_next_sample_i & ~gen_prev_q;
      pending_q  <= pending_d;
      timer_q    <= timer_d;
      win_src_q  <= win_src_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      miss_q     <= miss_d;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;
  assign sample_miss_o  = miss_q;

endmodule

// File: rtl/audio_source_arbiter.sv
// audio_source_arbiter: chooses between song player and keyboard voice for the
// single codec sample path, quantises key changes to beats and drains with
// silence on every source switch.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : slave side of audio_source_arbiter_if (controls, sources, codec output)
module audio_source_arbiter
  import audio_arb_pkg::*;
#(
  parameter int unsigned MIN_KEY_BEATS  = 2,
  parameter int unsigned DRAIN_SAMPLES  = 4,
  parameter int unsigned SAMPLE_TIMEOUT = 64
) (
  input logic                   clk,
  input logic                   reset,
  audio_source_arbiter_if.slave bus
);

  localparam logic [7:0] MinBeats  = 8'(MIN_KEY_BEATS);
  localparam logic [3:0] DrainLast = 4'(DRAIN_SAMPLES - 1);

  arb_state_e state_q, state_d;
  logic [7:0] beat_cnt_q, beat_cnt_d;
  logic [3:0] drain_cnt_q, drain_cnt_d;
  logic [3:0] key_code_q, key_code_d;
  logic       song_en_q, song_en_d;
  logic       key_en_q, key_en_d;
  logic       drain_ack;

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    key_code_d  = key_code_q;

    unique case (state_q)
      StIdle: begin
        if (bus.play) begin
          state_d = StSong;
        end else if (bus.key_val != 4'd0) begin
          state_d    = StKey;
          key_code_d = bus.key_val;
          beat_cnt_d = '0;
        end
      end
      StSong: begin
        if (!bus.play) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
        end
      end
      StKey: begin
        // Exit beats a coincident beat: key_code is cleared, not updated.
        if (bus.play || ((bus.key_val == 4'd0) && (beat_cnt_q >= MinBeats))) begin
          state_d     = StDrain;
          drain_cnt_d = '0;
          key_code_d  = 4'd0;
        end else if (bus.beat) begin
          if (beat_cnt_q < MinBeats) beat_cnt_d = beat_cnt_q + 8'd1;
          if (bus.key_val != 4'd0)   key_code_d = bus.key_val;
        end
      end
      StDrain: begin
        key_code_d = 4'd0;
        if (drain_ack) begin
          if (drain_cnt_q >= DrainLast) state_d = StIdle;
          else                          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    song_en_d = (state_d == StSong);
    key_en_d  = (state_d == StKey);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      key_code_q  <= '0;
      song_en_q   <= 1'b0;
      key_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      key_code_q  <= key_code_d;
      song_en_q   <= song_en_d;
      key_en_q    <= key_en_d;
    end
  end

  sample_handoff #(
    .SAMPLE_TIMEOUT (SAMPLE_TIMEOUT)
  ) u_sample_handoff (
    .clk_i                  (clk),
    .rst_ni                 (reset),
    .generate_next_sample_i (bus.generate_next_sample),
    .active_source_i        (state_q),
    .song_sample_i          (bus.song_sample),
    .song_ready_i           (bus.song_sample_ready),
    .key_sample_i           (bus.key_note_sample),
    .key_ready_i            (bus.key_note_sample_ready),
    .sample_o               (bus.sample_out),
    .sample_valid_o         (bus.sample_out_ready),
    .sample_miss_o          (bus.sample_miss),
    .drain_ack_o            (drain_ack)
  );

  assign bus.song_enable   = song_en_q;
  assign bus.key_enable    = key_en_q;
  assign bus.key_code      = key_code_q;
  assign bus.active_source = state_q;

endmodule

// File: tb/tb_audio_source_arbiter.sv
module tb_audio_source_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  audio_source_arbiter_if bus_if ();

  audio_source_arbiter #(
    .MIN_KEY_BEATS  (2),
    .DRAIN_SAMPLES  (4),
    .SAMPLE_TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest expected sample and its due cycle.
  always @(negedge clk) begin
    if (bus_if.sample_out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_pulse: cycle %0d got sample %h, required no pulse",
                 cyc, bus_if.sample_out);
      end else begin
        mon_e = exp_q.pop_front();
        n_vec++;
        if (bus_if.sample_out !== mon_e.data) begin
          n_err++;
          $display("FAIL sample_data: got %h required %h", bus_if.sample_out, mon_e.data);
        end
        n_vec++;
        if (cyc != mon_e.due) begin
          n_err++;
          $display("FAIL sample_cycle: got %0d required %0d", cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic expect_sample(input logic [15:0] data, input int due);
    exp_t e;
    e.data = data;
    e.due  = due;
    exp_q.push_back(e);
  endtask

  // Request answered directly with silence two cycles after the edge.
  task automatic zero_request();
    expect_sample(16'h0000, cyc + 2);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample = 1'b0;
    tick();
    tick();
  endtask

  task automatic drain_all();
    repeat (4) zero_request();
  endtask

  initial begin
    reset = 1'b0;
    bus_if.play                  = 1'b0;
    bus_if.key_val               = 4'd0;
    bus_if.beat                  = 1'b0;
    bus_if.generate_next_sample  = 1'b0;
    bus_if.song_sample           = 16'h0;
    bus_if.song_sample_ready     = 1'b0;
    bus_if.key_note_sample       = 16'h0;
    bus_if.key_note_sample_ready = 1'b0;
    repeat (3) tick();
    chk("rst_active_source", 32'(bus_if.active_source), 32'd0);
    chk("rst_song_enable", 32'(bus_if.song_enable), 32'd0);
    chk("rst_key_enable", 32'(bus_if.key_enable), 32'd0);
    chk("rst_key_code", 32'(bus_if.key_code), 32'd0);
    chk("rst_sample_out", 32'(bus_if.sample_out), 32'd0);
    chk("rst_sample_miss", 32'(bus_if.sample_miss), 32'd0);
    reset = 1'b1;
    tick();

    // Song mode and forwarding.
    bus_if.play = 1'b1;
    tick();
    chk("song_state", 32'(bus_if.active_source), 32'd1);
    chk("song_enable", 32'(bus_if.song_enable), 32'd1);
    chk("song_key_enable", 32'(bus_if.key_enable), 32'd0);

    expect_sample(16'h1234, cyc + 4);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample = 1'b0;
    tick();
    tick();
    bus_if.song_sample       = 16'h1234;
    bus_if.song_sample_ready = 1'b1;
    tick();
    bus_if.song_sample_ready = 1'b0;
    tick();
    tick();

    // Stray keyboard ready with no window: no output.
    bus_if.key_note_sample       = 16'hDEAD;
    bus_if.key_note_sample_ready = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b0;
    tick();

    // Stray keyboard ready inside a song window is ignored; song ready wins later.
    expect_sample(16'hBEEF, cyc + 4);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample = 1'b0;
    tick();
    bus_if.key_note_sample_ready = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b0;
    bus_if.song_sample           = 16'hBEEF;
    bus_if.song_sample_ready     = 1'b1;
    tick();
    bus_if.song_sample_ready = 1'b0;
    tick();
    chk("miss_before_timeout", 32'(bus_if.sample_miss), 32'd0);

    // Timeout: silence 65 cycles after the request edge.
    expect_sample(16'h0000, cyc + 65);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample = 1'b0;
    repeat (70) tick();
    chk("miss_after_timeout", 32'(bus_if.sample_miss), 32'd1);

    // Leave song: drain four silent samples, then idle.
    bus_if.play = 1'b0;
    tick();
    chk("drain_state", 32'(bus_if.active_source), 32'd3);
    chk("drain_song_enable", 32'(bus_if.song_enable), 32'd0);
    repeat (3) zero_request();
    chk("drain_after_3", 32'(bus_if.active_source), 32'd3);
    zero_request();
    chk("idle_after_drain", 32'(bus_if.active_source), 32'd0);
    chk("miss_sticky", 32'(bus_if.sample_miss), 32'd1);

    // Keyboard mode, beat-quantised code changes.
    bus_if.key_val = 4'd1;
    tick();
    chk("key_state", 32'(bus_if.active_source), 32'd2);
    chk("key_enable", 32'(bus_if.key_enable), 32'd1);
    chk("key_code_entry", 32'(bus_if.key_code), 32'd1);
    bus_if.key_val = 4'd11;
    tick();
    tick();
    chk("key_code_between_beats", 32'(bus_if.key_code), 32'd1);

    // Key-side forwarding; song ready in the same cycle must be ignored.
    expect_sample(16'h0ABC, cyc + 3);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample  = 1'b0;
    tick();
    bus_if.key_note_sample       = 16'h0ABC;
    bus_if.key_note_sample_ready = 1'b1;
    bus_if.song_sample           = 16'h5555;
    bus_if.song_sample_ready     = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b0;
    bus_if.song_sample_ready     = 1'b0;
    tick();

    bus_if.beat = 1'b1;
    tick();
    bus_if.beat = 1'b0;
    chk("key_code_on_beat", 32'(bus_if.key_code), 32'd11);

    // Release after one beat: held until the second beat.
    bus_if.key_val = 4'd0;
    tick();
    tick();
    chk("key_hold_state", 32'(bus_if.active_source), 32'd2);
    chk("key_hold_code", 32'(bus_if.key_code), 32'd11);
    bus_if.beat = 1'b1;
    tick();
    bus_if.beat = 1'b0;
    chk("key_second_beat_state", 32'(bus_if.active_source), 32'd2);
    tick();
    chk("key_min_exit", 32'(bus_if.active_source), 32'd3);
    chk("key_min_exit_code", 32'(bus_if.key_code), 32'd0);
    drain_all();
    chk("idle_after_key", 32'(bus_if.active_source), 32'd0);

    // play and key together from idle: song wins.
    bus_if.play    = 1'b1;
    bus_if.key_val = 4'd5;
    tick();
    chk("prio_state", 32'(bus_if.active_source), 32'd1);
    chk("prio_key_enable", 32'(bus_if.key_enable), 32'd0);
    tick();
    chk("prio_key_enable_later", 32'(bus_if.key_enable), 32'd0);
    bus_if.play    = 1'b0;
    bus_if.key_val = 4'd0;
    tick();
    drain_all();

    // play during KEY with a coincident beat: immediate drain, no code update.
    bus_if.key_val = 4'd3;
    tick();
    chk("key3_code", 32'(bus_if.key_code), 32'd3);
    bus_if.key_val = 4'd7;
    bus_if.play    = 1'b1;
    bus_if.beat    = 1'b1;
    tick();
    bus_if.play    = 1'b0;
    bus_if.beat    = 1'b0;
    bus_if.key_val = 4'd0;
    chk("play_exit_state", 32'(bus_if.active_source), 32'd3);
    chk("play_exit_code", 32'(bus_if.key_code), 32'd0);
    chk("play_exit_key_enable", 32'(bus_if.key_enable), 32'd0);
    drain_all();

    // Reset during KEY with a pending window: no pulse, all outputs cleared.
    bus_if.key_val = 4'd2;
    tick();
    expect_sample(16'h7777, cyc + 3);
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample  = 1'b0;
    tick();
    bus_if.key_note_sample       = 16'h7777;
    bus_if.key_note_sample_ready = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b0;
    tick();
    bus_if.generate_next_sample = 1'b1;
    tick();
    bus_if.generate_next_sample = 1'b0;
    tick();
    bus_if.key_val = 4'd0;
    reset = 1'b0;
    tick();
    chk("midrst_active_source", 32'(bus_if.active_source), 32'd0);
    chk("midrst_key_enable", 32'(bus_if.key_enable), 32'd0);
    chk("midrst_key_code", 32'(bus_if.key_code), 32'd0);
    chk("midrst_sample_out", 32'(bus_if.sample_out), 32'd0);
    chk("midrst_sample_miss", 32'(bus_if.sample_miss), 32'd0);
    chk("midrst_ready", 32'(bus_if.sample_out_ready), 32'd0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b1;
    tick();
    bus_if.key_note_sample_ready = 1'b0;
    repeat (80) tick();
    chk("post_reset_state", 32'(bus_if.active_source), 32'd0);
    chk("expected_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
